// File: rtl/fwft_byte_packer.sv
// Packs RATIO consecutive FWFT FIFO entries into one wide word with a lane keep mask.
// Idle timeout and flush push out partially filled words so trailing bytes never strand.
module fwft_byte_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fifo_rdata_vld,
  input  logic [IN_WIDTH-1:0]         fifo_rdata,
  output logic                        fifo_rden,
  input  logic                        flush,
  output logic                        out_vld,
  output logic [IN_WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]            out_keep,
  input  logic                        out_rdy
);

  localparam int OUT_W = IN_WIDTH * RATIO;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             flush_pend_q, flush_pend_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             out_vld_q, out_vld_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;

  logic             out_free;
  logic             timeout_hit;
  logic             emit_partial;
  logic             accept;
  logic             word_done;
  logic [OUT_W-1:0] acc_merged;
  logic [RATIO-1:0] keep_partial;

  assign out_free     = !out_vld_q || out_rdy;
  assign timeout_hit  = (TIMEOUT != 0) && (timer_q == TMR_MAX);
  assign emit_partial = (cnt_q != '0) && out_free && (flush_pend_q || timeout_hit);
  // A partial emit owns the output register this cycle, so the head entry waits.
  assign accept       = fifo_rdata_vld && !emit_partial && ((cnt_q != LAST_LANE) || out_free);
  assign word_done    = accept && (cnt_q == LAST_LANE);
  assign fifo_rden    = accept && rst_n;

  // Accumulator view with the incoming entry dropped into lane cnt, plus the partial keep mask.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign acc_merged[gi*IN_WIDTH +: IN_WIDTH] =
      (accept && (cnt_q == CNT_W'(gi))) ? fifo_rdata : acc_q[gi*IN_WIDTH +: IN_WIDTH];
    assign keep_partial[gi] = (CNT_W'(gi) < cnt_q);
  end

  always_comb begin
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q;
    acc_d        = acc_merged;
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;

    if (emit_partial || word_done) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (TIMEOUT == 0 || accept || emit_partial) begin
      timer_d = '0;
    end else if ((cnt_q != '0) && (timer_q != TMR_MAX)) begin
      timer_d = timer_q + TMR_W'(1);
    end

    // Any word leaving the packer satisfies an outstanding flush.
    if (emit_partial || word_done) begin
      flush_pend_d = 1'b0;
    end else if (flush && ((cnt_q != '0) || accept)) begin
      flush_pend_d = 1'b1;
    end

    if (word_done) begin
      out_vld_d  = 1'b1;
      out_data_d = acc_merged;
      out_keep_d = '1;
    end else if (emit_partial) begin
      out_vld_d  = 1'b1;
      out_data_d = acc_q;
      out_keep_d = keep_partial;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      acc_q        <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      acc_q        <= acc_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_keep = out_keep_q;

endmodule

// File: tb/tb_fwft_byte_packer.sv
// Scoreboard bench for fwft_byte_packer: a queue-backed FWFT FIFO model feeds the packer,
// expected words are queued with the stimulus and compared against accepted output words.
module tb_fwft_byte_packer;

  logic        clk;
  logic        rst_n;
  logic        fifo_rdata_vld;
  logic [7:0]  fifo_rdata;
  logic        fifo_rden;
  logic        flush;
  logic        out_vld;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_rdy;

  int tests_run;
  int tests_failed;
  int pop_cnt;

  logic [7:0]  src_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];

  logic        s_rden;
  logic        s_out_vld;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_keep;

  fwft_byte_packer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_rdata_vld (fifo_rdata_vld),
    .fifo_rdata     (fifo_rdata),
    .fifo_rden      (fifo_rden),
    .flush          (flush),
    .out_vld        (out_vld),
    .out_data       (out_data),
    .out_keep       (out_keep),
    .out_rdy        (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic refresh();
    fifo_rdata_vld = (src_q.size() != 0);
    fifo_rdata     = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  // One clock: sample at the falling edge, retire the popped head after the rising edge.
  task automatic step();
    logic [7:0] tmp;
    @(negedge clk);
    s_rden     = fifo_rden;
    s_out_vld  = out_vld;
    s_out_data = out_data;
    s_out_keep = out_keep;
    if (out_vld && out_rdy) begin
      obs_q.push_back({out_keep, out_data});
      $display("[TB] t=%0t word data=%h keep=%b", $time, out_data, out_keep);
    end
    @(posedge clk);
    #1;
    if (s_rden) begin
      tmp = src_q.pop_front();
      pop_cnt++;
    end
    refresh();
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'(first + i));
    refresh();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    out_rdy = 1'b1;
    src_q.push_back(8'hAB);
    refresh();
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (s_rden !== 1'b0) begin
        tests_failed++; $display("FAIL reset_rden: got %b expected 0", s_rden);
      end
      tests_run++;
      if (s_out_vld !== 1'b0 || s_out_keep !== 4'h0 || s_out_data !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_out: got vld=%b keep=%b data=%h expected 0/0/0", s_out_vld, s_out_keep, s_out_data);
      end
    end
    src_q.delete();
    refresh();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [31:0] w;
    logic [35:0] e, o;
    int rden_hi;
    pop_cnt = 0;
    rden_hi = 0;
    out_rdy = 1'b1;
    push_seq(0, 16);
    for (int wi = 0; wi < 4; wi++) begin
      for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(4*wi + l);
      exp_q.push_back({4'hF, w});
    end
    for (int i = 0; i < 24; i++) begin
      step();
      if (i < 16 && s_rden) rden_hi++;
      if (i == 3) begin
        tests_run++;
        if (s_out_vld !== 1'b0) begin
          tests_failed++; $display("FAIL stream_early_vld: got %b expected 0", s_out_vld);
        end
      end
      if (i == 4) begin
        tests_run++;
        if (s_out_vld !== 1'b1) begin
          tests_failed++; $display("FAIL stream_first_vld: got %b expected 1", s_out_vld);
        end
      end
    end
    tests_run++;
    if (rden_hi != 16) begin
      tests_failed++; $display("FAIL stream_rden_run: got %0d expected 16", rden_hi);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL stream_word: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++; $display("FAIL stream_word: got %h expected %h", o, e);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++; $display("FAIL stream_extra: got %0d extra words expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    logic [35:0] e, o;
    pop_cnt = 0;
    out_rdy = 1'b1;
    push_seq(0, 16);
    for (int wi = 0; wi < 4; wi++) begin
      for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(4*wi + l);
      exp_q.push_back({4'hF, w});
    end
    for (int i = 0; i < 4; i++) step();
    out_rdy = 1'b0;
    for (int i = 4; i < 14; i++) begin
      step();
      tests_run++;
      if (s_rden !== (i < 7)) begin
        tests_failed++; $display("FAIL bp_rden[%0d]: got %b expected %b", i, s_rden, (i < 7));
      end
      tests_run++;
      if (s_out_vld !== 1'b1 || s_out_data !== 32'h03020100) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got vld=%b data=%h expected 1/03020100", i, s_out_vld, s_out_data);
      end
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    tests_run++;
    if (pop_cnt != 16) begin
      tests_failed++; $display("FAIL bp_pops: got %0d expected 16", pop_cnt);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL bp_word: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++; $display("FAIL bp_word: got %h expected %h", o, e);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++; $display("FAIL bp_extra: got %0d extra words expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    logic [35:0] o;
    int idle;
    bit seen;
    pop_cnt = 0;
    out_rdy = 1'b1;
    src_q.push_back(8'hA1);
    src_q.push_back(8'hA2);
    refresh();
    step();
    step();
    idle = 0;
    seen = 1'b0;
    // Eight counting cycles bring the timer to 8, then the emit cycle loads the word.
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (s_out_vld) seen = 1'b1;
      else idle++;
    end
    tests_run++;
    if (!seen || idle != 9) begin
      tests_failed++; $display("FAIL timeout_latency: got seen=%b low_samples=%0d expected 1/9", seen, idle);
    end
    tests_run++;
    if (obs_q.size() == 0) begin
      tests_failed++; $display("FAIL timeout_word: got none expected 30000a2a1");
    end else begin
      o = obs_q.pop_front();
      if (o !== {4'b0011, 32'h0000A2A1}) begin
        tests_failed++; $display("FAIL timeout_word: got %h expected 30000a2a1", o);
      end
    end
    for (int i = 0; i < 3; i++) step();
    obs_q.delete();
  endtask

  task automatic test_flush();
    logic [35:0] o;
    int n;
    pop_cnt = 0;
    out_rdy = 1'b1;
    src_q.push_back(8'h55);
    refresh();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++; $display("FAIL flush_count: got %0d words expected 1", obs_q.size());
    end
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      tests_run++;
      if (o !== {4'b0001, 32'h00000055}) begin
        tests_failed++; $display("FAIL flush_word: got %h expected 100000055", o);
      end
    end
    obs_q.delete();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_out_vld) n++;
    end
    tests_run++;
    if (n != 0 || obs_q.size() != 0) begin
      tests_failed++; $display("FAIL flush_empty: got %0d vld cycles expected 0", n);
    end
    obs_q.delete();
  endtask

  task automatic test_flush_race();
    logic [35:0] e, o;
    pop_cnt = 0;
    out_rdy = 1'b1;
    push_seq(8'h10, 7);
    push_seq(8'h44, 4);
    exp_q.push_back({4'hF, 32'h13121110});
    exp_q.push_back({4'b0111, 32'h00161514});
    exp_q.push_back({4'hF, 32'h47464544});
    for (int i = 0; i < 4; i++) step();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if (s_rden !== 1'b0) begin
      tests_failed++; $display("FAIL race_blocked: got rden=%b expected 0", s_rden);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (s_rden !== 1'b0 || s_out_data !== 32'h13121110) begin
        tests_failed++; $display("FAIL race_hold: got rden=%b data=%h expected 0/13121110", s_rden, s_out_data);
      end
    end
    out_rdy = 1'b1;
    step();
    tests_run++;
    if (s_rden !== 1'b0) begin
      tests_failed++; $display("FAIL race_emit_priority: got rden=%b expected 0", s_rden);
    end
    step();
    tests_run++;
    if (s_rden !== 1'b1 || s_out_keep !== 4'b0111 || s_out_data !== 32'h00161514) begin
      tests_failed++;
      $display("FAIL race_partial: got rden=%b keep=%b data=%h expected 1/0111/00161514", s_rden, s_out_keep, s_out_data);
    end
    for (int i = 0; i < 10; i++) step();
    tests_run++;
    if (pop_cnt != 11) begin
      tests_failed++; $display("FAIL race_pops: got %0d expected 11", pop_cnt);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL race_word: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++; $display("FAIL race_word: got %h expected %h", o, e);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++; $display("FAIL race_extra: got %0d extra words expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_midword();
    logic [35:0] o;
    out_rdy = 1'b1;
    push_seq(8'h01, 2);
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    push_seq(8'h03, 4);
    for (int i = 0; i < 8; i++) step();
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++; $display("FAIL midreset_count: got %0d words expected 1", obs_q.size());
    end
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      tests_run++;
      if (o !== {4'hF, 32'h06050403}) begin
        tests_failed++; $display("FAIL midreset_word: got %h expected f06050403", o);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    pop_cnt        = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    out_rdy        = 1'b0;
    fifo_rdata_vld = 1'b0;
    fifo_rdata     = 8'h00;
    test_reset();
    test_stream();
    test_backpressure();
    test_timeout();
    test_flush();
    test_flush_race();
    test_reset_midword();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fwft_byte_packer.md
Name: fwft_byte_packer

Overview:
- Downstream consumer of the single-clock FWFT FIFO.
- Pops IN_WIDTH-bit entries through the FIFO's rden/rdata/rdata_vld interface and packs RATIO consecutive entries into one wide word.
- Presents each word on a valid/ready output with a per-lane keep mask.
- Idle timeout and explicit flush emit partially filled words, so trailing bytes never strand in the packer.

Parameters:
- IN_WIDTH, 8: width of the FIFO read data.
- RATIO, 4: input entries per output word; ≥2.
- TIMEOUT, 64: idle cycles before a partial word is emitted; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_rdata_vld  in  1  FIFO head entry valid (FWFT).
- fifo_rdata  in  IN_WIDTH  FIFO head data.
- fifo_rden  out  1  pop FIFO head; combinational.
- flush  in  1  single-cycle request to emit the current partial word.
- out_vld  out  1  output word valid.
- out_data  out  IN_WIDTH*RATIO  packed word; first-popped entry in lane 0 (LSBs).
- out_keep  out  RATIO  lane-valid mask, contiguous from lane 0.
- out_rdy  in  1  downstream accept.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_vld=0, out_data=0, out_keep=0.
  - Lane count cnt=0, idle timer=0, flush_pend=0, accumulator cleared.
  - fifo_rden=0 while in reset.
- Output register:
  - Single entry.
  - out_free = !out_vld || out_rdy.
  - out_vld/out_data/out_keep hold stable while out_vld && !out_rdy.
- Accept rule:
  - accept = fifo_rdata_vld && !emit_partial && (cnt < RATIO-1 || out_free).
  - fifo_rden = accept.
  - Accepted entry is written to lane cnt on the same edge.
- Full-word completion: accept with cnt==RATIO-1 loads the output register on that edge:
  - out_data = accumulator with the new lane.
  - out_keep = all ones.
  - out_vld = 1.
  - cnt = 0.
  - Accumulator is cleared to 0.
- Latency: the completing entry popped at edge N gives out_vld=1 after edge N.
- Throughput: 1 entry/cycle sustained when out_rdy=1; no bubble at word boundaries.
- Backpressure: with out_vld && !out_rdy and cnt==RATIO-1, fifo_rden=0. The FIFO head stays unconsumed and no data is lost or duplicated.
- Idle timer:
  - Counts cycles with cnt>0 && !accept.
  - Cleared on any accept or emit.
  - Saturates at TIMEOUT.
- Flush:
  - flush=1 sets flush_pend if cnt>0 or an accept occurs that cycle.
  - flush with cnt==0 and no accept is a no-op.
- Partial emit:
  - emit_partial = cnt>0 && out_free && (flush_pend || (TIMEOUT!=0 && timer==TIMEOUT)).
  - On emit_partial: out_data = accumulator, with unused lanes zero.
  - On emit_partial: out_keep = (1<<cnt)-1, out_vld=1, cnt=0.
  - On emit_partial: timer=0, flush_pend=0.
  - Emit has priority over accept: fifo_rden=0 in the emit cycle, and the next entry starts the new word.
- A pending partial emit with the output busy waits until out_free; accepts continue meanwhile. If the word fills first, it is emitted as a full word and flush_pend is cleared.
- An output handshake (out_vld && out_rdy) with no new load clears out_vld.
- Reset asserted mid-word discards the accumulator and any held output word.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with fifo_rdata_vld=1.
  - Required: fifo_rden=0, out_vld=0, out_keep=0 throughout.
- Streaming, RATIO=4:
  - Stimulus: FIFO presents 0x00..0x0F back-to-back, out_rdy=1.
  - Required: fifo_rden high 16 consecutive cycles.
  - Required: 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, keep=4'hF.
  - Required: first out_vld the cycle after popping 0x03.
- Backpressure:
  - Stimulus: same stream, out_rdy=0 for 10 cycles after the first word.
  - Required: fifo_rden drops after 0x06 is popped.
  - Required: out_data holds 0x03020100.
  - Required: on release, output sequence matches the streaming case with no loss or duplication.
- Timeout, TIMEOUT=8:
  - Stimulus: push 0xA1, 0xA2, then the FIFO goes empty.
  - Required: after exactly 8 idle cycles, out_vld=1, out_data=0x0000A2A1, out_keep=4'b0011.
- Flush:
  - Stimulus: push 0x55, pulse flush next cycle, out_rdy=1.
  - Required: out_data=0x00000055, keep=4'b0001.
  - Required: flush with cnt=0 produces no output.
- Flush racing a completing entry:
  - Stimulus: cnt=3, flush pulsed while out_vld=1, out_rdy=0, next entry 0x44 valid.
  - Required: on out_rdy, the held word drains.
  - Required: the partial 3-lane word is emitted with keep=4'b0111.
  - Required: 0x44 lands in lane 0 of the following word.
